// File: rtl/mux_nxm_reg.sv
// Registered NIN-ring + per-output-local-port steering mux with duplicate/illegal-select flags.
// Latency: 1 cycle from inputs to out_data/out_valid/dup_err; one word per output per cycle.
// Backpressure: none, outputs update every cycle; MUX_NXM_STATS_EN adds saturating flit_cnt.
module mux_nxm_reg #(
    parameter int NIN  = 4,
    parameter int NOUT = 2,
    parameter int W    = 64,
    localparam int SW  = $clog2(NIN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NIN*W-1:0]     in_data,
    input  logic [NIN-1:0]       in_valid,
    input  logic [NOUT*W-1:0]    loc_data,
    input  logic [NOUT-1:0]      loc_valid,
    input  logic [NOUT*SW-1:0]   sel,
    input  logic [NOUT-1:0]      sel_load,
    output logic [NOUT*W-1:0]    out_data,
    output logic [NOUT-1:0]      out_valid,
    output logic                 dup_err,
    output logic [NOUT-1:0]      sel_err
`ifdef MUX_NXM_STATS_EN
    ,
    output logic [NOUT*16-1:0]   flit_cnt
`endif
);

    logic [SW-1:0]   sel_q   [NOUT];
    logic [SW-1:0]   eff     [NOUT];
    logic [W-1:0]    mux_dat [NOUT];
    logic [NOUT-1:0] mux_vld;
    logic [NOUT-1:0] sel_bad;
    logic            dup_hit;

    // A load bypasses the held select so it steers the word captured in the same cycle.
    always_comb begin
        for (int o = 0; o < NOUT; o++) begin
            eff[o]     = sel_load[o] ? sel[o*SW +: SW] : sel_q[o];
            sel_bad[o] = sel_load[o] && (sel[o*SW +: SW] > SW'(NIN));
            mux_dat[o] = loc_data[o*W +: W];
            mux_vld[o] = loc_valid[o];
            for (int i = 0; i < NIN; i++) begin
                if (eff[o] == SW'(i)) begin
                    mux_dat[o] = in_data[i*W +: W];
                    mux_vld[o] = in_valid[i];
                end
            end
        end
    end

    // Duplicate: some valid ring input is claimed by two or more outputs.
    always_comb begin
        logic seen;
        dup_hit = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < NIN; i++) begin
            seen = 1'b0;
            for (int o = 0; o < NOUT; o++) begin
                if (in_valid[i] && (eff[o] == SW'(i))) begin
                    if (seen) dup_hit = 1'b1;
                    seen = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NOUT; o++) sel_q[o] <= SW'(NIN);
            out_data  <= '0;
            out_valid <= '0;
            dup_err   <= 1'b0;
            sel_err   <= '0;
        end else begin
            for (int o = 0; o < NOUT; o++) begin
                if (sel_load[o]) sel_q[o] <= sel[o*SW +: SW];
                out_data[o*W +: W] <= mux_dat[o];
                out_valid[o]       <= mux_vld[o];
                sel_err[o]         <= sel_err[o] | sel_bad[o];
            end
            dup_err <= dup_hit;
        end
    end

`ifdef MUX_NXM_STATS_EN
    // Counters track the valid being registered this edge and stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_cnt <= '0;
        end else begin
            for (int o = 0; o < NOUT; o++) begin
                if (mux_vld[o] && (flit_cnt[o*16 +: 16] != 16'hFFFF))
                    flit_cnt[o*16 +: 16] <= flit_cnt[o*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mux_nxm_reg.md
# mux_nxm_reg

Parametrised, registered ring-port multiplexer for the hierarchical-ring router datapath. It steers NIN ring inputs plus one dedicated local port per output onto NOUT outputs. Each output has a held select register and a one-cycle output register. The block flags duplicated and illegal selections, and can optionally count forwarded flits per output. It sits between the ring input latches and the ring/eject output stage, where the fixed 4-input, 2-output combinational steering used previously.

## Interface
- NIN, default 4: number of ring inputs, 2..8.
- NOUT, default 2: number of outputs, each with its own local input, 1..4.
- W, default 64: flit/control word width.
- SW, localparam = clog2(NIN+1): select field width.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  NIN*W  ring input words; input i occupies bits [i*W +: W].
- in_valid  in  NIN  per-ring-input valid.
- loc_data  in  NOUT*W  local input word dedicated to output o, at [o*W +: W].
- loc_valid  in  NOUT  per-local-input valid.
- sel  in  NOUT*SW  new select value for output o, at [o*SW +: SW].
- sel_load  in  NOUT  loads sel for output o this cycle.
- out_data  out  NOUT*W  registered output words.
- out_valid  out  NOUT  registered output valids.
- dup_err  out  1  registered pulse: two or more outputs forwarded the same valid ring input.
- sel_err  out  NOUT  sticky: an illegal select value was loaded for output o.
- flit_cnt  out  NOUT*16  per-output forwarded-flit counters; present only with MUX_NXM_STATS_EN.

## Operation
- Select register sel_q[o], SW bits per output.
  - Reset value NIN, which selects the local port.
  - On sel_load[o], sel_q[o] <= sel[o].
- Effective select: eff[o] = sel_load[o] ? sel[o] : sel_q[o]. A load therefore takes effect for the word captured in the same cycle.
- Decode of eff[o]:
  - 0..NIN-1: ring input eff[o], both data and valid.
  - NIN: local port o.
  - Greater than NIN: illegal. The output forwards the local port, and sel_err[o] sets if the illegal value was loaded via sel_load.
- Output register, updated every cycle with no enable:
  - out_data[o] <= selected data.
  - out_valid[o] <= selected valid.
  - Data is forwarded even when valid is 0, so no X-gating is needed by consumers.
- Duplicate check, per cycle:
  - Condition: for any ring input i, at least two outputs have eff == i and in_valid[i] = 1.
  - dup_err <= 1 on that condition, else 0.
  - Flits are still forwarded to all selecting outputs; broadcast of an invalid word is not an error.
- sel_err[o] clears only on rst.
- Independent outputs: any combination of sel_load bits may be asserted in the same cycle.

## Timing
- Reset values, applied immediately on rst assertion without waiting for a clock edge:
  - out_data = 0, out_valid = 0, dup_err = 0, sel_err = 0.
  - sel_q = NIN for every output.
  - flit_cnt = 0.
- Latency: input to out_data/out_valid is exactly 1 cycle.
- Throughput: one word per output per cycle.
- Select change: a sel_load in cycle t affects the output visible at t+1. The held value persists from t+1 on.
- dup_err covers the same cycle as the outputs it describes; both appear at t+1.
- rst asserted mid-stream discards the in-flight output register contents. The first post-reset output reflects the local ports.

## Configuration
- MUX_NXM_STATS_EN defined:
  - flit_cnt[o] increments by 1 on each rising edge where the newly registered out_valid[o] = 1.
  - Each counter saturates at 16'hFFFF and never wraps.
  - Counters reset to 0 on rst.
- MUX_NXM_STATS_EN undefined:
  - The flit_cnt port and counters are absent.
  - All other behaviour is identical.

## Test plan
- Reset: assert rst asynchronously with in_valid = 4'hF and loc_valid = 2'b11 -> immediately out_valid = 0 and out_data = 0. After release, the first cycle shows out_valid = 2'b11 with out_data[o] = loc_data[o].
- Steering: load sel = {1, 2} while in_data words are 'h11/'h22/'h33/'h44, all valid -> next cycle out0 = 'h33, out1 = 'h22. With sel_load low afterwards, the selection holds over 5 further cycles.
- Same-cycle load: sel_load = 2'b01 with sel0 = 3 in cycle t -> out0 = in3 at t+1, and out1 is unchanged in source.
- Duplicate: sel0 = sel1 = 0 with in_valid[0] = 1 -> dup_err = 1 for that cycle. With in_valid[0] = 0 -> dup_err = 0.
- Illegal select: NIN = 4, load sel0 = 7 -> out0 = loc_data[0] and sel_err[0] = 1. It stays 1 after reloading sel0 = 0, until rst.
- Stats (MUX_NXM_STATS_EN): preload 65530 valid flits on out0, then 10 more -> flit_cnt[0] = 16'hFFFF, no wrap. Build without the macro -> the block compiles and the previous five tests pass.
